uart_cmd_parser: RTL and testbench

- Sits between the UART receiver and pwm_ctrl. Consumes received bytes and decodes short ASCII commands.
- Drives the PWM configuration bus (pow2_cfg, pow5_cfg, duty_cfg, cfg_valid) with a single-cycle cfg_valid strobe per accepted command.
- Returns a one-byte status ('K' or 'E') toward the UART transmitter over a valid/ready handshake.

---
 rtl/uart_cmd_parser.sv | 192 +++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// Decodes ASCII commands from the UART receiver into PWM configuration updates.
// Accepts "D<1..3 digits>" and "P<0-3><0-3>", terminated by CR or LF, and answers 'K' or 'E'.
module uart_cmd_parser #(
    parameter int unsigned MAX_DUTY    = 100,
    parameter int unsigned TIMEOUT_CYC = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [1:0] pow2_cfg,
    output logic [1:0] pow5_cfg,
    output logic [6:0] duty_cfg,
    output logic       cfg_valid,
    output logic       cmd_err,
    output logic [7:0] resp_data,
    output logic       resp_valid,
    input  logic       resp_ready
);
    localparam int unsigned ACC_W = 10;
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [ACC_W-1:0] MAX_ACC  = ACC_W'(MAX_DUTY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_D  = 8'h44;
    localparam logic [7:0] CH_P  = 8'h50;
    localparam logic [7:0] CH_K  = 8'h4B;
    localparam logic [7:0] CH_E  = 8'h45;

    typedef enum logic [2:0] {
        IDLE,
        DUTY_DIG,
        POW_A,
        POW_B,
        POW_END,
        FLUSH
    } state_t;

    state_t            state, state_nxt;
    logic [ACC_W-1:0]  acc, acc_nxt;
    logic [1:0]        ndig, ndig_nxt;
    logic [1:0]        p2_lat, p2_nxt;
    logic [1:0]        p5_lat, p5_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;

    logic [7:0]        ch;
    logic              is_term;
    logic              is_dig;
    logic              is_pdig;
    logic              acc_duty;
    logic              acc_pow;
    logic              err;

    // Next-state decode: one byte per rx_valid, otherwise run the inter-byte timeout
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        ndig_nxt  = ndig;
        p2_nxt    = p2_lat;
        p5_nxt    = p5_lat;
        cnt_nxt   = cnt;
        acc_duty  = 1'b0;
        acc_pow   = 1'b0;
        err       = 1'b0;

        ch = rx_data;
        if (rx_data inside {[8'h61:8'h7A]}) begin
            ch = rx_data - 8'h20;
        end
        is_term = (ch == CH_CR) || (ch == CH_LF);
        is_dig  = ch inside {[8'h30:8'h39]};
        is_pdig = ch inside {[8'h30:8'h33]};

        if (rx_valid) begin
            cnt_nxt = '0;
            unique case (state)
                IDLE: begin
                    if (ch == CH_D) begin
                        state_nxt = DUTY_DIG;
                        acc_nxt   = '0;
                        ndig_nxt  = '0;
                    end else if (ch == CH_P) begin
                        state_nxt = POW_A;
                    end else if (!(is_term || ch == CH_SP)) begin
                        err       = 1'b1;
                        state_nxt = FLUSH;
                    end
                end
                DUTY_DIG: begin
                    if (is_dig && ndig != 2'd3) begin
                        acc_nxt  = acc * ACC_W'(10) + ACC_W'(ch[3:0]);
                        ndig_nxt = ndig + 2'd1;
                    end else if (is_term && ndig != 2'd0 && acc <= MAX_ACC) begin
                        acc_duty  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        err       = 1'b1;
                        state_nxt = is_term ? IDLE : FLUSH;
                    end
                end
                POW_A: begin
                    if (is_pdig) begin
                        p2_nxt    = ch[1:0];
                        state_nxt = POW_B;
                    end else begin
                        err       = 1'b1;
                        state_nxt = is_term ? IDLE : FLUSH;
                    end
                end
                POW_B: begin
                    if (is_pdig) begin
                        p5_nxt    = ch[1:0];
                        state_nxt = POW_END;
                    end else begin
                        err       = 1'b1;
                        state_nxt = is_term ? IDLE : FLUSH;
                    end
                end
                POW_END: begin
                    if (is_term) begin
                        acc_pow   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        err       = 1'b1;
                        state_nxt = FLUSH;
                    end
                end
                FLUSH: begin
                    if (is_term) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE) begin
            if (cnt == CNT_LAST) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                err       = (state != FLUSH);
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            ndig       <= '0;
            p2_lat     <= '0;
            p5_lat     <= '0;
            cnt        <= '0;
            pow2_cfg   <= '0;
            pow5_cfg   <= '0;
            duty_cfg   <= '0;
            cfg_valid  <= 1'b0;
            cmd_err    <= 1'b0;
            resp_data  <= '0;
            resp_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            ndig      <= ndig_nxt;
            p2_lat    <= p2_nxt;
            p5_lat    <= p5_nxt;
            cnt       <= cnt_nxt;
            cfg_valid <= acc_duty | acc_pow;
            cmd_err   <= err;
            if (acc_duty) begin
                duty_cfg <= 7'(acc);
            end
            if (acc_pow) begin
                pow2_cfg <= p2_lat;
                pow5_cfg <= p5_lat;
            end
            // A new status overwrites any pending one, even in a handshake cycle
            if (acc_duty | acc_pow | err) begin
                resp_valid <= 1'b1;
                resp_data  <= err ? CH_E : CH_K;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomized bench for uart_cmd_parser against a string-level grammar model.
module tb_uart_cmd_parser;
    localparam int TO = 100;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [1:0] pow2_cfg;
    logic [1:0] pow5_cfg;
    logic [6:0] duty_cfg;
    logic       cfg_valid;
    logic       cmd_err;
    logic [7:0] resp_data;
    logic       resp_valid;
    logic       resp_ready;

    uart_cmd_parser #(.MAX_DUTY(100), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .pow2_cfg   (pow2_cfg),
        .pow5_cfg   (pow5_cfg),
        .duty_cfg   (duty_cfg),
        .cfg_valid  (cfg_valid),
        .cmd_err    (cmd_err),
        .resp_data  (resp_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready)
    );

    always #5 clk = ~clk;

    int n_vec;
    int n_bad;
    int err_pulses;
    bit rand_ready;

    // Reference state: the bytes of the command in progress, as a string
    logic [7:0] line[$];
    bit         flushing;
    int         idle;
    logic [6:0] m_duty;
    logic [1:0] m_pow2;
    logic [1:0] m_pow5;
    logic       m_cfg_valid;
    logic       m_cmd_err;
    logic [7:0] m_resp_data;
    logic       m_resp_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] upcase(input logic [7:0] b);
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
        return b;
    endfunction

    function automatic bit prefix_ok();
        if (line[0] == 8'h44) begin
            if (line.size() > 4) return 1'b0;
            for (int i = 1; i < line.size(); i++)
                if (line[i] < 8'h30 || line[i] > 8'h39) return 1'b0;
            return 1'b1;
        end
        if (line.size() > 3) return 1'b0;
        for (int i = 1; i < line.size(); i++)
            if (line[i] < 8'h30 || line[i] > 8'h33) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int duty_value();
        int v = 0;
        for (int i = 1; i < line.size(); i++) v = v * 10 + int'(line[i] - 8'h30);
        return v;
    endfunction

    task automatic model_step();
        logic [7:0] c;
        bit term, perr, pok, hs;
        m_cfg_valid = 1'b0;
        m_cmd_err   = 1'b0;
        perr = 1'b0;
        pok  = 1'b0;
        hs   = m_resp_valid && resp_ready;
        if (!rst_n) begin
            line.delete();
            flushing = 1'b0;
            idle = 0;
            m_duty = '0; m_pow2 = '0; m_pow5 = '0;
            m_resp_data = '0; m_resp_valid = 1'b0;
            return;
        end
        if (rx_valid) begin
            idle = 0;
            c = upcase(rx_data);
            term = (c == CR) || (c == LF);
            if (flushing) begin
                if (term) flushing = 1'b0;
            end else if (line.size() == 0) begin
                if (c == 8'h44 || c == 8'h50) line.push_back(c);
                else if (!(term || c == 8'h20)) begin perr = 1'b1; flushing = 1'b1; end
            end else if (term) begin
                if (line[0] == 8'h44 && line.size() >= 2 && duty_value() <= 100) begin
                    m_duty = 7'(duty_value());
                    pok = 1'b1;
                end else if (line[0] == 8'h50 && line.size() == 3) begin
                    m_pow2 = 2'(line[1] - 8'h30);
                    m_pow5 = 2'(line[2] - 8'h30);
                    pok = 1'b1;
                end else begin
                    perr = 1'b1;
                end
                line.delete();
            end else begin
                line.push_back(c);
                if (!prefix_ok()) begin perr = 1'b1; line.delete(); flushing = 1'b1; end
            end
        end else if (line.size() != 0 || flushing) begin
            idle++;
            if (idle == TO) begin
                if (line.size() != 0) perr = 1'b1;
                line.delete();
                flushing = 1'b0;
                idle = 0;
            end
        end
        m_cfg_valid = pok;
        m_cmd_err   = perr;
        if (pok || perr) begin
            m_resp_valid = 1'b1;
            m_resp_data  = perr ? 8'h45 : 8'h4B;
        end else if (hs) begin
            m_resp_valid = 1'b0;
        end
    endtask

    // Compare process: advance the model on each edge and check every output just after it
    always @(posedge clk) begin
        model_step();
        #1;
        if (cmd_err === 1'b1) err_pulses++;
        check("cfg_valid", 32'(cfg_valid), 32'(m_cfg_valid));
        check("cmd_err", 32'(cmd_err), 32'(m_cmd_err));
        check("duty_cfg", 32'(duty_cfg), 32'(m_duty));
        check("pow2_cfg", 32'(pow2_cfg), 32'(m_pow2));
        check("pow5_cfg", 32'(pow5_cfg), 32'(m_pow5));
        check("resp_valid", 32'(resp_valid), 32'(m_resp_valid));
        check("resp_data", 32'(resp_data), 32'(m_resp_data));
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        if (rand_ready) resp_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_str(input string s, input int maxgap);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], int'($urandom_range(0, maxgap)));
    endtask

    task automatic cmd(input string body, input logic [7:0] t);
        send_str(body, 0);
        send_byte(t, 0);
    endtask

    function automatic logic [7:0] rdig(input int lo, input int hi);
        return 8'(8'h30 + $urandom_range(lo, hi));
    endfunction

    function automatic logic [7:0] rterm();
        return ($urandom_range(0, 1) != 0) ? CR : LF;
    endfunction

    initial begin
        int e0;
        int kind;
        int n;
        clk = 1'b0;
        rst_n = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        resp_ready = 1'b1;
        rand_ready = 1'b0;
        n_vec = 0;
        n_bad = 0;
        err_pulses = 0;
        line.delete();
        flushing = 1'b0;
        idle = 0;
        m_duty = '0; m_pow2 = '0; m_pow5 = '0;
        m_cfg_valid = 1'b0; m_cmd_err = 1'b0;
        m_resp_data = '0; m_resp_valid = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_duty", 32'(duty_cfg), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        rst_n = 1'b1;

        cmd("D25", CR);
        check("d25_valid", 32'(cfg_valid), 32'd1);
        check("d25_duty", 32'(duty_cfg), 32'd25);
        check("d25_pow2", 32'(pow2_cfg), 32'd0);
        check("d25_resp", 32'(resp_data), 32'h4B);
        @(negedge clk);
        check("d25_pulse_len", 32'(cfg_valid), 32'd0);

        cmd("P21", LF);
        check("p21_pow2", 32'(pow2_cfg), 32'd2);
        check("p21_pow5", 32'(pow5_cfg), 32'd1);
        check("p21_duty", 32'(duty_cfg), 32'd25);
        check("p21_resp", 32'(resp_data), 32'h4B);

        e0 = err_pulses;
        cmd("D101", CR);
        check("d101_resp", 32'(resp_data), 32'h45);
        cmd("D1000", CR);
        cmd("D", CR);
        cmd("P41", CR);
        check("bad_err_count", 32'(err_pulses - e0), 32'd4);
        check("bad_duty", 32'(duty_cfg), 32'd25);
        check("bad_pow2", 32'(pow2_cfg), 32'd2);
        cmd("d100", CR);
        check("d100_duty", 32'(duty_cfg), 32'd100);
        check("d100_resp", 32'(resp_data), 32'h4B);

        e0 = err_pulses;
        cmd("DX5", CR);
        cmd("D5", CR);
        check("flush_err_count", 32'(err_pulses - e0), 32'd1);
        check("flush_duty", 32'(duty_cfg), 32'd5);

        e0 = err_pulses;
        send_str("D3", 0);
        repeat (TO + 10) @(negedge clk);
        check("timeout_err_count", 32'(err_pulses - e0), 32'd1);
        check("timeout_duty", 32'(duty_cfg), 32'd5);
        check("timeout_resp", 32'(resp_data), 32'h45);
        cmd("D7", CR);
        check("d7_duty", 32'(duty_cfg), 32'd7);

        resp_ready = 1'b0;
        cmd("D10", CR);
        cmd("Q", CR);
        check("hold_resp_valid", 32'(resp_valid), 32'd1);
        check("hold_resp_data", 32'(resp_data), 32'h45);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("drain_resp_valid", 32'(resp_valid), 32'd0);

        send_byte(8'h50, 0);
        send_byte(8'h31, 0);
        #3 rst_n = 1'b0;
        #1;
        check("arst_duty", 32'(duty_cfg), 32'd0);
        check("arst_pow2", 32'(pow2_cfg), 32'd0);
        check("arst_resp_data", 32'(resp_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        resp_ready = 1'b1;
        cmd("D9", CR);
        check("post_rst_duty", 32'(duty_cfg), 32'd9);

        rand_ready = 1'b1;
        for (int k = 0; k < 500; k++) begin
            kind = int'($urandom_range(0, 7));
            case (kind)
                0: begin
                    send_byte(($urandom_range(0, 1) != 0) ? 8'h64 : 8'h44, int'($urandom_range(0, 2)));
                    n = int'($urandom_range(1, 3));
                    for (int i = 0; i < n; i++)
                        send_byte(rdig(0, (i == 0) ? 1 : 9), int'($urandom_range(0, 2)));
                    send_byte(rterm(), int'($urandom_range(0, 2)));
                end
                1: begin
                    send_byte(($urandom_range(0, 1) != 0) ? 8'h70 : 8'h50, int'($urandom_range(0, 2)));
                    send_byte(rdig(0, 4), int'($urandom_range(0, 2)));
                    send_byte(rdig(0, 4), int'($urandom_range(0, 2)));
                    send_byte(rterm(), int'($urandom_range(0, 2)));
                end
                2: begin
                    send_byte(8'($urandom), int'($urandom_range(0, 2)));
                    send_byte(rterm(), int'($urandom_range(0, 2)));
                end
                3: begin
                    n = int'($urandom_range(0, 2));
                    send_byte((n == 0) ? 8'h44 : ((n == 1) ? 8'h50 : 8'h58), 0);
                    if ($urandom_range(0, 1) != 0) send_byte(rdig(0, 3), 0);
                    repeat ($urandom_range(TO - 4, TO + 1)) @(negedge clk);
                    send_byte(rterm(), 0);
                end
                4: begin
                    send_byte(8'h20, int'($urandom_range(0, 2)));
                    send_byte(rterm(), int'($urandom_range(0, 2)));
                end
                5: begin
                    send_byte(8'h44, 0);
                    for (int i = 0; i < 4; i++) send_byte(rdig(0, 9), int'($urandom_range(0, 1)));
                    send_byte(rterm(), 0);
                end
                6: begin
                    send_byte(8'h50, 0);
                    for (int i = 0; i < 3; i++) send_byte(($urandom_range(0, 4) == 0) ? 8'h44 : rdig(0, 3), 0);
                    send_byte(rterm(), 0);
                end
                default: begin
                    n = int'($urandom_range(1, 3));
                    for (int i = 0; i < n; i++) send_byte(8'($urandom_range(32, 122)), int'($urandom_range(0, 2)));
                    send_byte(rterm(), int'($urandom_range(0, 2)));
                end
            endcase
        end

        rand_ready = 1'b0;
        resp_ready = 1'b1;
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
